// File: rtl/fulladd_bist_if.sv
// Pin bundle between the full-adder BIST controller and the adder it exercises.
// The master side drives start and the adder's s/cout. The slave side is the controller.
interface fulladd_bist_if;
  logic       start;
  logic       s;
  logic       cout;
  logic       x;
  logic       y;
  logic       cin;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [7:0] fail_mask;
  logic [2:0] first_fail_vec;

  modport master (
    output start, s, cout,
    input  x, y, cin, busy, done, pass, err_cnt, fail_mask, first_fail_vec
  );

  modport slave (
    input  start, s, cout,
    output x, y, cin, busy, done, pass, err_cnt, fail_mask, first_fail_vec
  );
endinterface

// File: rtl/fulladd_bist.sv
// Exhaustive self-test of a one-bit full adder: walks all eight {x,y,cin} vectors,
// holds each for SETTLE cycles, checks s/cout at the end of the window and reports.
module fulladd_bist #(
  parameter int unsigned SETTLE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fulladd_bist_if.slave  io_bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned VEC_W  = 3;
  localparam int unsigned ERR_W  = 4;
  localparam int unsigned MASK_W = 8;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(7);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [VEC_W-1:0]    r_vec;
  logic [CNT_W-1:0]    r_settle;
  logic                r_x;
  logic                r_y;
  logic                r_cin;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [ERR_W-1:0]    r_err_cnt;
  logic [MASK_W-1:0]   r_fail_mask;
  logic [VEC_W-1:0]    r_first_fail;

  state_t              w_state_nxt;
  logic [VEC_W-1:0]    w_vec_nxt;
  logic [CNT_W-1:0]    w_settle_nxt;
  logic                w_x_nxt;
  logic                w_y_nxt;
  logic                w_cin_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_pass_nxt;
  logic [ERR_W-1:0]    w_err_cnt_nxt;
  logic [MASK_W-1:0]   w_fail_mask_nxt;
  logic [VEC_W-1:0]    w_first_fail_nxt;
  logic [VEC_W-1:0]    w_vec_inc;

  logic                w_s_exp;
  logic                w_cout_exp;
  logic                w_mismatch;
  logic                w_window_end;

  // Golden response for the vector currently on the pins; vec bits are {x,y,cin}.
  assign w_s_exp      = r_vec[2] ^ r_vec[1] ^ r_vec[0];
  assign w_cout_exp   = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);
  assign w_mismatch   = (io_bus.s != w_s_exp) || (io_bus.cout != w_cout_exp);
  assign w_window_end = (r_settle == SETTLE_LAST);
  assign w_vec_inc    = r_vec + VEC_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_vec_nxt        = r_vec;
    w_settle_nxt     = r_settle;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_cin_nxt        = r_cin;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;
    w_pass_nxt       = r_pass;
    w_err_cnt_nxt    = r_err_cnt;
    w_fail_mask_nxt  = r_fail_mask;
    w_first_fail_nxt = r_first_fail;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (io_bus.start) begin
          w_state_nxt      = ST_APPLY;
          w_vec_nxt        = '0;
          w_settle_nxt     = '0;
          w_x_nxt          = 1'b0;
          w_y_nxt          = 1'b0;
          w_cin_nxt        = 1'b0;
          w_busy_nxt       = 1'b1;
          w_done_nxt       = 1'b0;
          w_pass_nxt       = 1'b0;
          w_err_cnt_nxt    = '0;
          w_fail_mask_nxt  = '0;
          w_first_fail_nxt = '0;
        end
      end

      ST_APPLY: begin
        if (w_window_end) begin
          if (w_mismatch) begin
            w_fail_mask_nxt[r_vec] = 1'b1;
            w_err_cnt_nxt          = r_err_cnt + ERR_W'(1);
            if (r_err_cnt == '0) begin
              w_first_fail_nxt = r_vec;
            end
          end
          w_settle_nxt = '0;
          if (r_vec != VEC_LAST) begin
            w_vec_nxt = w_vec_inc;
            w_x_nxt   = w_vec_inc[2];
            w_y_nxt   = w_vec_inc[1];
            w_cin_nxt = w_vec_inc[0];
          end else begin
            w_state_nxt = ST_DONE;
            w_vec_nxt   = '0;
            w_x_nxt     = 1'b0;
            w_y_nxt     = 1'b0;
            w_cin_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_err_cnt_nxt == '0);
          end
        end else begin
          w_settle_nxt = r_settle + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_vec        <= '0;
      r_settle     <= '0;
      r_x          <= 1'b0;
      r_y          <= 1'b0;
      r_cin        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
      r_fail_mask  <= '0;
      r_first_fail <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_vec        <= w_vec_nxt;
      r_settle     <= w_settle_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_cin        <= w_cin_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_fail_mask  <= w_fail_mask_nxt;
      r_first_fail <= w_first_fail_nxt;
    end
  end

  assign io_bus.x              = r_x;
  assign io_bus.y              = r_y;
  assign io_bus.cin            = r_cin;
  assign io_bus.busy           = r_busy;
  assign io_bus.done           = r_done;
  assign io_bus.pass           = r_pass;
  assign io_bus.err_cnt        = r_err_cnt;
  assign io_bus.fail_mask      = r_fail_mask;
  assign io_bus.first_fail_vec = r_first_fail;

endmodule
